// File: rtl/nx_msg_decoder.sv
// nx_msg_decoder: header decode and three-way routing of the
// arbitrated inbound message stream of a mesh node.
module nx_msg_decoder #(
    parameter int STREAM_WIDTH = 32,
    parameter int ROW_W = 4,
    parameter int COL_W = 4,
    localparam int PAYLOAD_W = STREAM_WIDTH - ROW_W - COL_W - 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ROW_W-1:0]        node_row_i,
    input  logic [COL_W-1:0]        node_col_i,
    input  logic [STREAM_WIDTH-1:0] msg_data_i,
    input  logic [1:0]              msg_dir_i,
    input  logic                    msg_valid_i,
    output logic                    msg_ready_o,
    output logic [STREAM_WIDTH-1:0] byp_data_o,
    output logic [1:0]              byp_dir_o,
    output logic                    byp_valid_o,
    input  logic                    byp_ready_i,
    output logic [PAYLOAD_W-1:0]    instr_data_o,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [PAYLOAD_W-1:0]    map_data_o,
    output logic                    map_valid_o,
    output logic [PAYLOAD_W-1:0]    sig_data_o,
    output logic                    sig_valid_o,
    output logic [7:0]              drop_count_o
);

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_MAP  = 2'd1,
        CMD_SIG  = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    logic [ROW_W-1:0]     hdr_row;
    logic [COL_W-1:0]     hdr_col;
    cmd_e                 hdr_cmd;
    logic [PAYLOAD_W-1:0] hdr_payload;

    logic is_fwd;
    dir_e route_dir;

    logic byp_free;
    logic instr_free;
    logic accept;

    logic take_byp;
    logic take_instr;
    logic take_map;
    logic take_sig;
    logic take_drop;

    // Arrival direction carries no routing meaning here.
    logic msg_dir_unused;
    assign msg_dir_unused = ^msg_dir_i;

    assign hdr_row     = msg_data_i[STREAM_WIDTH-1 -: ROW_W];
    assign hdr_col     = msg_data_i[STREAM_WIDTH-ROW_W-1 -: COL_W];
    assign hdr_cmd     = cmd_e'(msg_data_i[PAYLOAD_W +: 2]);
    assign hdr_payload = msg_data_i[PAYLOAD_W-1:0];

    // Dimension-order routing: resolve row first, then column.
    always_comb begin
        is_fwd    = 1'b1;
        route_dir = DIR_N;
        if (hdr_row < node_row_i) begin
            route_dir = DIR_N;
        end else if (hdr_row > node_row_i) begin
            route_dir = DIR_S;
        end else if (hdr_col < node_col_i) begin
            route_dir = DIR_W;
        end else if (hdr_col > node_col_i) begin
            route_dir = DIR_E;
        end else begin
            is_fwd = 1'b0;
        end
    end

    // A slot can take a new entry when empty or draining this cycle.
    assign byp_free   = !byp_valid_o || byp_ready_i;
    assign instr_free = !instr_valid_o || instr_ready_i;

    // Ready depends only on the destination of the head message.
    always_comb begin
        msg_ready_o = byp_free;
        if (msg_valid_i && !is_fwd) begin
            unique case (hdr_cmd)
                CMD_LOAD: msg_ready_o = instr_free;
                CMD_MAP:  msg_ready_o = 1'b1;
                CMD_SIG:  msg_ready_o = 1'b1;
                CMD_RSVD: msg_ready_o = 1'b1;
            endcase
        end
    end

    assign accept = msg_valid_i && msg_ready_o;

    assign take_byp   = accept && is_fwd;
    assign take_instr = accept && !is_fwd && (hdr_cmd == CMD_LOAD);
    assign take_map   = accept && !is_fwd && (hdr_cmd == CMD_MAP);
    assign take_sig   = accept && !is_fwd && (hdr_cmd == CMD_SIG);
    assign take_drop  = accept && !is_fwd && (hdr_cmd == CMD_RSVD);

    // Bypass slot: forwarded message, unmodified, plus egress port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byp_valid_o <= 1'b0;
            byp_data_o  <= '0;
            byp_dir_o   <= 2'd0;
        end else if (byp_free) begin
            byp_valid_o <= take_byp;
            if (take_byp) begin
                byp_data_o <= msg_data_i;
                byp_dir_o  <= route_dir;
            end
        end
    end

    // Instruction slot: payload for the node's instruction loader.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_valid_o <= 1'b0;
            instr_data_o  <= '0;
        end else if (instr_free) begin
            instr_valid_o <= take_instr;
            if (take_instr) begin
                instr_data_o <= hdr_payload;
            end
        end
    end

    // Output-map command: single-cycle pulse, payload held afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_valid_o <= 1'b0;
            map_data_o  <= '0;
        end else begin
            map_valid_o <= take_map;
            if (take_map) begin
                map_data_o <= hdr_payload;
            end
        end
    end

    // Signal command: single-cycle pulse, payload held afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_valid_o <= 1'b0;
            sig_data_o  <= '0;
        end else begin
            sig_valid_o <= take_sig;
            if (take_sig) begin
                sig_data_o <= hdr_payload;
            end
        end
    end

    // Saturating count of reserved-command messages swallowed here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_count_o <= 8'd0;
        end else if (take_drop && (drop_count_o != 8'hFF)) begin
            drop_count_o <= drop_count_o + 8'd1;
        end
    end

endmodule
